// File: rtl/melody_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : melody_pkg
//  Description : Shared types and constants for the melody sequencer:
//                FSM state encoding, melody entry layout, melody ROM and the
//                pitch-to-divider table.
//  Revision    : 1.0 - initial release
// ============================================================================
package melody_pkg;

    // Sequencer states, explicit 3-bit encoding
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_PLAY = 3'd2,
        ST_GAP  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    // Melody entry layout: {trem, pitch[3:0], dur[3:0]}
    localparam int ENTRY_W   = 9;
    localparam int PITCH_W   = 4;
    localparam int DUR_W     = 4;
    localparam int TBL_DIV_W = 12;

    typedef struct packed {
        logic               trem;
        logic [PITCH_W-1:0] pitch;
        logic [DUR_W-1:0]   dur;
    } entry_t;

    localparam logic [ENTRY_W-1:0] END_MARKER = 9'h000;

    // Melody: C4 for 3 ticks, A4 with tremolo, a 2-tick rest, A4, then end.
    // Entries past the end marker keep the table full for longer melodies.
    localparam logic [ENTRY_W-1:0] MELODY_ROM [16] = '{
        9'h012, 9'h1A0, 9'h001, 9'h0A0,
        9'h000, 9'h031, 9'h1C0, 9'h072,
        9'h083, 9'h0F0, 9'h1E1, 9'h0B0,
        9'h0C2, 9'h1D0, 9'h0A1, 9'h040
    };

    // Tone divider per pitch code; code 0 is silence
    localparam logic [TBL_DIV_W-1:0] PITCH_DIV [16] = '{
        12'd0,    12'd1911, 12'd1804, 12'd1703,
        12'd1607, 12'd1517, 12'd1432, 12'd1351,
        12'd1276, 12'd1204, 12'd1136, 12'd1073,
        12'd1012, 12'd956,  12'd902,  12'd851
    };

    // Octave shift: up alone halves, down alone doubles, otherwise unchanged.
    // One extra bit of headroom keeps the doubled value exact.
    function automatic logic [TBL_DIV_W:0] octave_div(
        input logic [TBL_DIV_W-1:0] base,
        input logic                 up,
        input logic                 dn
    );
        logic [TBL_DIV_W:0] res;
        case ({up, dn})
            2'b10:   res = {2'b00, base[TBL_DIV_W-1:1]};
            2'b01:   res = {base, 1'b0};
            default: res = {1'b0, base};
        endcase
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/melody_sequencer_tempo_tick.sv
`default_nettype none
// ============================================================================
//  Module      : tempo_tick
//  Description : Tempo prescaler. Counts 0..TICK_DIV-1 and flags the last
//                count as a one-cycle tick; clr_i restarts the count at 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module tempo_tick #(
    parameter int TICK_DIV = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    output logic tick_o
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: restart on clear or on wrap, otherwise increment
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr_i || (cnt_q == CNT_LAST)) begin
            cnt_d = '0;
        end
    end

    // Count register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == CNT_LAST);

endmodule
`default_nettype wire

// File: rtl/melody_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : melody_sequencer
//  Description : Tempo-driven sequencer that walks the melody ROM and drives
//                the tone generator's divider, gate and tremolo controls.
//                Supports start/stop, looping, octave shift and a one-tick
//                articulation gap between notes.
//  Revision    : 1.0 - initial release
// ============================================================================
module melody_sequencer
    import melody_pkg::*;
#(
    parameter int TICK_DIV   = 250000,
    parameter int DIV_W      = 12,
    parameter int NOTE_COUNT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             loop_en,
    input  logic             octave_up,
    input  logic             octave_dn,
    output logic [DIV_W-1:0] tone_div,
    output logic             tone_on,
    output logic             tremolo_en,
    output logic             busy,
    output logic [3:0]       note_idx,
    output logic             done
);

    localparam logic [3:0] LAST_IDX = 4'(NOTE_COUNT - 1);

    state_e state_q, state_d;

    logic [DIV_W-1:0] tone_div_q, tone_div_d;
    logic             tone_on_q, tone_on_d;
    logic             trem_q, trem_d;
    logic             busy_q, busy_d;
    logic [3:0]       note_idx_q, note_idx_d;
    logic             done_q, done_d;
    logic [DUR_W-1:0] dur_q, dur_d;
    logic [DUR_W-1:0] beat_q, beat_d;

    entry_t             w_entry;
    logic               w_is_end;
    logic               w_last_idx;
    logic               w_tick;
    logic               w_play_done;
    logic               w_clr;
    logic [TBL_DIV_W:0] w_shift;
    logic [DIV_W-1:0]   w_div;

    assign w_entry     = entry_t'(MELODY_ROM[note_idx_q]);
    assign w_is_end    = (MELODY_ROM[note_idx_q] == END_MARKER);
    assign w_last_idx  = (note_idx_q == LAST_IDX);
    assign w_play_done = w_tick && (beat_q == dur_q);
    assign w_shift     = octave_div(PITCH_DIV[w_entry.pitch], octave_up, octave_dn);
    assign w_div       = DIV_W'(w_shift);

    // Any state change restarts the tempo count, so PLAY and GAP start at 0
    assign w_clr = (state_d != state_q);

    tempo_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_tempo_tick (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (w_clr),
        .tick_o (w_tick)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; stop overrides everything
    always_comb begin
        state_d = state_q;
        if (stop) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (start) state_d = ST_LOAD;
                ST_LOAD: begin
                    if (w_is_end) begin
                        state_d = loop_en ? ST_LOAD : ST_DONE;
                    end else begin
                        state_d = ST_PLAY;
                    end
                end
                ST_PLAY: if (w_play_done) state_d = ST_GAP;
                ST_GAP: begin
                    if (w_tick) begin
                        state_d = (w_last_idx && !loop_en) ? ST_DONE : ST_LOAD;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Output next values, decided from the transition being taken
    always_comb begin
        tone_div_d = tone_div_q;
        tone_on_d  = tone_on_q;
        trem_d     = trem_q;
        note_idx_d = note_idx_q;
        dur_d      = dur_q;
        beat_d     = beat_q;
        busy_d     = (state_d != ST_IDLE);
        done_d     = (state_d == ST_DONE);
        case (state_d)
            ST_IDLE, ST_DONE: begin
                tone_div_d = '0;
                tone_on_d  = 1'b0;
                trem_d     = 1'b0;
                note_idx_d = '0;
            end
            ST_LOAD: begin
                // Advance after a gap unless the melody wraps; every other
                // way into LOAD (start, loop restart) begins at entry 0
                tone_on_d  = 1'b0;
                note_idx_d = (state_q == ST_GAP && !w_last_idx) ? note_idx_q + 4'd1 : 4'd0;
            end
            ST_PLAY: begin
                if (state_q == ST_LOAD) begin
                    tone_div_d = w_div;
                    tone_on_d  = (w_entry.pitch != '0);
                    trem_d     = w_entry.trem;
                    dur_d      = w_entry.dur;
                    beat_d     = '0;
                end else if (w_tick) begin
                    beat_d = beat_q + 1'b1;
                end
            end
            ST_GAP: begin
                tone_on_d = 1'b0;
            end
            default: begin
                tone_on_d = 1'b0;
            end
        endcase
    end

    // Output and note-context registers
    always_ff @(posedge clk) begin
        if (rst) begin
            tone_div_q <= '0;
            tone_on_q  <= 1'b0;
            trem_q     <= 1'b0;
            busy_q     <= 1'b0;
            note_idx_q <= '0;
            done_q     <= 1'b0;
            dur_q      <= '0;
            beat_q     <= '0;
        end else begin
            tone_div_q <= tone_div_d;
            tone_on_q  <= tone_on_d;
            trem_q     <= trem_d;
            busy_q     <= busy_d;
            note_idx_q <= note_idx_d;
            done_q     <= done_d;
            dur_q      <= dur_d;
            beat_q     <= beat_d;
        end
    end

    assign tone_div   = tone_div_q;
    assign tone_on    = tone_on_q;
    assign tremolo_en = trem_q;
    assign busy       = busy_q;
    assign note_idx   = note_idx_q;
    assign done       = done_q;

endmodule
`default_nettype wire
